rr_mux_arbiter: RTL and testbench
=================================

# rr_mux_arbiter

Round-robin arbiter that shares one 4:1 word-select datapath among four requesters and drives a single valid/ready output channel. It picks a requester, steers its data onto the output, and holds the grant for up to BURST accepted beats. It then rotates priority to the next requester. It sits between four producer ports and one downstream consumer.

## Interface
- WIDTH, default 8: data word width per requester.
- BURST, default 4: maximum accepted beats per grant; must be ≥ 1.
---
- clk, input, 1: sole clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 4: per-requester valid. Bit i is held high with stable data until ack[i].
- data, input, 4*WIDTH: packed requester words; requester i occupies data[i*WIDTH +: WIDTH].
- ack, output, 4: per-requester accept. Combinational; ack[i] = grant[i] & out_valid & out_ready.
- grant, output, 4: one-hot registered grant; all zero when idle.
- select, output, 2: registered index of the granted requester; drives the word mux.
- out_valid, output, 1: req[select] while a grant is active, else 0.
- out_data, output, WIDTH: data word of requester select (combinational mux).
- out_ready, input, 1: downstream accept.

## Operation
- Two states: IDLE and BUSY.
- Round-robin pointer ptr (2 bits) names the highest-priority requester.
- IDLE:
  - grant = 0 and out_valid = 0.
  - If any req bit is set, pick the first set bit scanning ptr, ptr+1, … mod 4.
  - Register select = pick, grant = one-hot(pick), beat count cnt = 0, and go to BUSY.
  - If no req bit is set, stay in IDLE.
- BUSY, transfer (out_valid & out_ready):
  - ack[select] = 1 and cnt increments.
  - If cnt+1 == BURST, end the grant.
- BUSY, req[select] low:
  - out_valid = 0 and the grant ends. This is the requester releasing early.
- BUSY, out_ready low with req[select] high:
  - Hold state. No ack, cnt unchanged, out_data follows the stable requester data.
- Grant end:
  - Next state is IDLE, grant clears, and ptr = select+1 mod 4.
  - select keeps its last value.
- Arithmetic and widths:
  - cnt width is clog2(BURST+1).
  - ptr and select wrap modulo 4: 3+1 → 0.
- Simultaneous events:
  - A transfer on the last beat and new requests in the same cycle: the grant still ends, and new requests are evaluated in the following IDLE cycle.
  - Requests from non-granted requesters never preempt an active grant.

## Timing
- Reset values: state = IDLE, ptr = 0, select = 0, grant = 0, cnt = 0. Hence out_valid = 0 and ack = 0. out_data = data word 0.
- Asserting rst_n low forces these values immediately, without a clock edge, including mid-burst.
- Arbitration latency: req rising in IDLE gives grant and out_valid on the next cycle.
- Rotation overhead: exactly one IDLE cycle between consecutive grants.
- Peak throughput: BURST beats per BURST+1 cycles with out_ready held high.
- ack, out_valid and out_data are combinational from req, data, out_ready and registered state. There is no register stage in the data path.

## Structure
- Package rr_mux_arbiter_pkg:
  - NREQ = 4 and SEL_W = 2.
  - State enum {IDLE, BUSY}.
  - Function onehot4(sel).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: pick[1:0] and any.
- The word mux and the FSM stay in the top module.

## Test plan
- Reset: hold rst_n = 0 with req = 4'hF → grant = 0, out_valid = 0, ack = 0, select = 0. After release, the first grant goes to requester 0.
- Single requester: req = 4'b0100, data[2] = 8'hA5, out_ready = 1.
  - Next cycle: grant = 4'b0100, select = 2, out_valid = 1, out_data = 8'hA5.
  - 4 acks, then one IDLE cycle, then requester 2 is regranted.
- All request: req = 4'hF held, out_ready = 1.
  - Grant order 0, 1, 2, 3, 0.
  - Each grant gives 4 beats followed by 1 idle cycle, so 16 beats in 20 cycles.
- Backpressure: out_ready = 0 for 3 cycles mid-burst after 2 beats → out_valid stays 1, ack = 0, out_data stable, cnt stays 2. The burst completes with 2 more beats.
- Early release: requester 1 drops req after 2 acks while req[2] = 1.
  - Grant ends and ptr = 2.
  - After one IDLE cycle, grant = 4'b0100.
- Asynchronous reset mid-burst: pull rst_n low between clock edges during BUSY → grant, out_valid and ack go to 0 immediately. After release, ptr = 0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: first set req bit scanning ptr, ptr+1, ...
module rr_pick
  import rr_mux_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from lowest priority to highest so the last hit (closest to ptr) wins.
  always_comb begin
    pick = ptr;
    idx  = '0;
    any  = |req;
    for (int i = NREQ-1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing a 4:1 word mux onto one valid/ready channel.
// A grant lasts up to BURST accepted beats or until the owner drops req,
// then one IDLE cycle re-arbitrates starting after the last owner.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       grant,
  output logic [SEL_W-1:0]      select,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready
);

  localparam int CW = $clog2(BURST + 1);

  state_t                        state, state_n;
  logic [SEL_W-1:0]              ptr, ptr_n, select_n;
  logic [NREQ-1:0]               grant_n;
  logic [CW-1:0]                 cnt, cnt_n, cnt_inc;
  logic [SEL_W-1:0]              pick;
  logic                          any;
  logic                          xfer;
  logic                          done;
  logic [NREQ-1:0][WIDTH-1:0]    words;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // Datapath is purely combinational off the registered select.
  assign words     = data;
  assign out_data  = words[select];
  assign out_valid = (state == BUSY) & req[select];
  assign xfer      = out_valid & out_ready;
  assign ack       = grant & {NREQ{xfer}};
  assign cnt_inc   = cnt + CW'(1);

  // Next-state: arbitrate in IDLE, count beats and detect grant end in BUSY.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    select_n = select;
    grant_n  = grant;
    cnt_n    = cnt;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_n  = BUSY;
          select_n = pick;
          grant_n  = onehot4(pick);
          cnt_n    = '0;
        end
      end
      BUSY: begin
        if (!req[select]) begin
          done = 1'b1;
        end else if (out_ready) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(BURST)) done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Grant end: rotate priority past the last owner; select is left as-is.
    if (done) begin
      state_n = IDLE;
      grant_n = '0;
      ptr_n   = select + SEL_W'(1);
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      select <= '0;
      grant  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      select <= select_n;
      grant  <= grant_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboarded bench for rr_mux_arbiter: expected beats are queued at stimulus
// time and popped whenever the DUT acks.
module tb_rr_mux_arbiter;
  import rr_mux_arbiter_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] data;
  logic [3:0]     ack;
  logic [3:0]     grant;
  logic [1:0]     select;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   g;
    logic [W-1:0] d;
  } beat_t;

  beat_t exp_q[$];

  rr_mux_arbiter #(.WIDTH(W), .BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
    .ack       (ack),
    .grant     (grant),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_word(input int i, input logic [W-1:0] v);
    data[i*W +: W] = v;
  endtask

  task automatic push_beats(input int id, input logic [W-1:0] v, input int n);
    beat_t b;
    b.g = onehot4(2'(id));
    b.d = v;
    repeat (n) exp_q.push_back(b);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    data      = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_word(i, 8'h10 + 8'(i));
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL reset_grant got %h want 0", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack got %h want 0", ack); end
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL reset_select got %0d want 0", select); end
    checks++; if (out_data !== 8'h10) begin errors++; $display("FAIL reset_data got %h want 10", out_data); end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", grant); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL reset_first_ack got %b want 0001", ack); end
  endtask

  task automatic test_single();
    logic [3:0] exp_g [6];
    beat_t b;
    exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100};
    apply_reset();
    set_word(2, 8'hA5);
    req       = 4'b0100;
    out_ready = 1'b1;
    push_beats(2, 8'hA5, 5);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL single_grant c%0d got %b want %b", k+1, grant, exp_g[k]); end
      checks++; if (out_valid !== (exp_g[k] != 0)) begin errors++; $display("FAIL single_valid c%0d got %b", k+1, out_valid); end
      if (k == 0) begin
        checks++; if (select !== 2'd2) begin errors++; $display("FAIL single_select got %0d want 2", select); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", out_data); end
      end
      if (ack !== 4'h0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb unexpected ack %b", ack); end
        else begin
          b = exp_q.pop_front();
          if (ack !== b.g || out_data !== b.d) begin errors++; $display("FAIL single_sb got %b/%h want %b/%h", ack, out_data, b.g, b.d); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_all_request();
    logic [3:0] eg;
    int beats;
    beat_t b;
    apply_reset();
    for (int i = 0; i < 4; i++) set_word(i, 8'hA0 + 8'(i));
    req       = 4'hF;
    out_ready = 1'b1;
    for (int g = 0; g < 4; g++) push_beats(g, 8'hA0 + 8'(g), 4);
    push_beats(0, 8'hA0, 1);
    beats = 0;
    for (int k = 0; k < 21; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      eg = (k % 5 == 4) ? 4'h0 : onehot4(2'((k / 5) % 4));
      checks++; if (grant !== eg) begin errors++; $display("FAIL all_grant c%0d got %b want %b", k+1, grant, eg); end
      if (ack !== 4'h0) begin
        if (k < 20) beats++;
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL all_sb unexpected ack %b", ack); end
        else begin
          b = exp_q.pop_front();
          if (ack !== b.g || out_data !== b.d) begin errors++; $display("FAIL all_sb got %b/%h want %b/%h", ack, out_data, b.g, b.d); end
        end
      end
    end
    checks++; if (beats != 16) begin errors++; $display("FAIL all_beats got %0d want 16", beats); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL all_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic exp_a [8];
    beat_t b;
    exp_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    apply_reset();
    set_word(0, 8'h3C);
    req       = 4'b0001;
    out_ready = 1'b1;
    push_beats(0, 8'h3C, 4);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 2) out_ready = 1'b0;
      if (k == 5) out_ready = 1'b1;
      @(negedge clk);
      checks++; if (ack !== (exp_a[k] ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL bp_ack c%0d got %b want %b", k+1, ack, exp_a[k]); end
      if (k >= 2 && k <= 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got %b want 1", k+1, out_valid); end
        checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL bp_data c%0d got %h want 3c", k+1, out_data); end
        checks++; if (dut.cnt !== 3'd2) begin errors++; $display("FAIL bp_cnt c%0d got %0d want 2", k+1, dut.cnt); end
      end
      if (k == 7) begin
        checks++; if (grant !== 4'h0) begin errors++; $display("FAIL bp_end_grant got %b want 0000", grant); end
      end
      if (ack !== 4'h0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_sb unexpected ack %b", ack); end
        else begin
          b = exp_q.pop_front();
          if (ack !== b.g || out_data !== b.d) begin errors++; $display("FAIL bp_sb got %b/%h want %b/%h", ack, out_data, b.g, b.d); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_early_release();
    logic [3:0] exp_g [5];
    beat_t b;
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0100};
    apply_reset();
    set_word(1, 8'h11);
    set_word(2, 8'h22);
    req       = 4'b0110;
    out_ready = 1'b1;
    push_beats(1, 8'h11, 2);
    push_beats(2, 8'h22, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 2) req = 4'b0100;
      @(negedge clk);
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL er_grant c%0d got %b want %b", k+1, grant, exp_g[k]); end
      if (k == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL er_valid got %b want 0", out_valid); end
        checks++; if (ack !== 4'h0) begin errors++; $display("FAIL er_ack got %b want 0000", ack); end
      end
      if (k == 3) begin
        checks++; if (dut.ptr !== 2'd2) begin errors++; $display("FAIL er_ptr got %0d want 2", dut.ptr); end
      end
      if (ack !== 4'h0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL er_sb unexpected ack %b", ack); end
        else begin
          b = exp_q.pop_front();
          if (ack !== b.g || out_data !== b.d) begin errors++; $display("FAIL er_sb got %b/%h want %b/%h", ack, out_data, b.g, b.d); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL er_sb_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_g [6];
    beat_t b;
    exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
    apply_reset();
    set_word(0, 8'h70);
    set_word(2, 8'h5A);
    set_word(3, 8'h6B);
    req       = 4'b0100;
    out_ready = 1'b1;
    push_beats(2, 8'h5A, 4);
    push_beats(3, 8'h6B, 1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 4) req = 4'b1000;
      @(negedge clk);
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL ar_grant c%0d got %b want %b", k+1, grant, exp_g[k]); end
      if (ack !== 4'h0) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL ar_sb unexpected ack %b", ack); end
        else begin
          b = exp_q.pop_front();
          if (ack !== b.g || out_data !== b.d) begin errors++; $display("FAIL ar_sb got %b/%h want %b/%h", ack, out_data, b.g, b.d); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ar_sb_left got %0d want 0", exp_q.size()); end
    // Mid-burst, between edges.
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (grant !== 4'h0) begin errors++; $display("FAIL ar_grant_async got %b want 0000", grant); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid_async got %b want 0", out_valid); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL ar_ack_async got %b want 0000", ack); end
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL ar_select_async got %0d want 0", select); end
    checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL ar_ptr_async got %0d want 0", dut.ptr); end
    req = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ar_regrant got %b want 0001", grant); end
    checks++; if (out_data !== 8'h70) begin errors++; $display("FAIL ar_regrant_data got %h want 70", out_data); end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    data      = '0;
    test_reset();
    test_single();
    test_all_request();
    test_backpressure();
    test_early_release();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
